// File: rtl/h_pfn_drain_pkg.sv
// Shared definitions for the hot-PFN buffer drainer (package h_pfn_pkg).
// Holds the drain FSM state encoding, the PFN entry type and the default
// geometry constants that must agree with the hot-PFN buffer itself.
package h_pfn_pkg;

    localparam int H_PFN_NUM_ENTRIES = 1024;
    localparam int H_PFN_ENTRY_WIDTH = 32;
    localparam int H_PFN_RD_LAT      = 2;
    localparam int H_PFN_FIFO_DEPTH  = 4;
    localparam int H_PFN_RST_TIMEOUT = 16;

    typedef enum logic [1:0] {
        DS_IDLE  = 2'd0,
        DS_READ  = 2'd1,
        DS_CHECK = 2'd2,
        DS_FIN   = 2'd3
    } drain_state_e;

    typedef logic [H_PFN_ENTRY_WIDTH-1:0] pfn_entry_t;

endpackage

// File: rtl/h_pfn_skid_fifo.sv
// Small synchronous FIFO used as the output skid buffer of the drainer.
// Head is presented combinationally; count lets the reader compute credits.
// Push while full and pop while empty are ignored defensively.
module h_pfn_skid_fifo
    import h_pfn_pkg::*;
#(
    parameter int WIDTH = H_PFN_ENTRY_WIDTH,
    parameter int DEPTH = H_PFN_FIFO_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/h_pfn_drain.sv
// Drainer for the hot-PFN buffer: reads entries [0, wr_idx) out of the
// buffer BRAM, streams them on a valid/ready port, then resets the buffer
// write index in a cycle where no tracker write would be lost.
// Optional statistics counters are built when H_PFN_DRAIN_STATS_EN is defined.
module h_pfn_drain
    import h_pfn_pkg::*;
#(
    parameter int NUM_ENTRIES = H_PFN_NUM_ENTRIES,
    parameter int ENTRY_WIDTH = H_PFN_ENTRY_WIDTH,
    parameter int NUM_IDX_BIT = $clog2(NUM_ENTRIES),
    parameter int RD_LAT      = H_PFN_RD_LAT,
    parameter int FIFO_DEPTH  = H_PFN_FIFO_DEPTH,
    parameter int RST_TIMEOUT = H_PFN_RST_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   drain_req,
    input  logic [NUM_IDX_BIT-1:0] auto_thresh,
    input  logic [NUM_IDX_BIT-1:0] buf_wr_idx,
    input  logic                   buf_wr_en,
    input  logic                   buf_wr_overflow,
    output logic [NUM_IDX_BIT-1:0] buf_rd_idx,
    output logic                   buf_rd_en,
    input  logic [ENTRY_WIDTH-1:0] buf_rd_data,
    output logic                   buf_wr_idx_rst,
    output logic                   pfn_valid,
    input  logic                   pfn_ready,
    output logic [ENTRY_WIDTH-1:0] pfn_data,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_IDX_BIT-1:0] drained_cnt,
    output logic                   ovf_sticky,
    input  logic                   ovf_clr,
`ifdef H_PFN_DRAIN_STATS_EN
    output logic [31:0]            stat_drains,
    output logic [31:0]            stat_entries,
    output logic [31:0]            stat_stall,
`endif
    output logic [15:0]            lost_cnt
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(RST_TIMEOUT) + 1;

    localparam logic [1:0] S_IDLE  = DS_IDLE;
    localparam logic [1:0] S_READ  = DS_READ;
    localparam logic [1:0] S_CHECK = DS_CHECK;
    localparam logic [1:0] S_FIN   = DS_FIN;

    logic [1:0]             state;
    logic [NUM_IDX_BIT-1:0] limit;
    logic [NUM_IDX_BIT-1:0] rd_ptr;
    logic [NUM_IDX_BIT-1:0] total;
    logic [TMR_W-1:0]       timer;
    logic [RD_LAT-1:0]      tag_sr;
    logic [7:0]             inflight;
    logic [7:0]             occupied;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_empty;
    logic                   start;
    logic                   issue;
    logic                   pop;
    logic                   read_done;
    logic                   grow;
    logic                   timeout_hit;
    logic                   fifo_flush;

    assign start = drain_req || ((auto_thresh != '0) && (buf_wr_idx >= auto_thresh));

    // Reads still travelling through the BRAM pipeline hold credit until pushed.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 8'(tag_sr[i]);
        end
    end

    assign occupied    = 8'(fifo_count) + inflight;
    assign issue       = !reset && (state == S_READ) && (rd_ptr < limit)
                         && (occupied < 8'(FIFO_DEPTH));
    assign read_done   = (rd_ptr == limit) && (inflight == '0) && fifo_empty;
    assign grow        = buf_wr_idx > limit;
    assign timeout_hit = (timer == TMR_W'(RST_TIMEOUT - 1));
    assign fifo_flush  = (state == S_IDLE) && start;

    assign buf_rd_en      = issue;
    assign buf_rd_idx     = rd_ptr;
    assign pfn_valid      = !reset && !fifo_empty;
    assign pop            = pfn_valid && pfn_ready;
    assign busy           = (state != S_IDLE);
    assign done           = !reset && (state == S_FIN);
    assign buf_wr_idx_rst = !reset && (state == S_CHECK) && !grow
                            && (!buf_wr_en || timeout_hit);

    h_pfn_skid_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (fifo_flush),
        .push      (tag_sr[RD_LAT-1]),
        .push_data (buf_rd_data),
        .pop       (pop),
        .head      (pfn_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Tag shift register: a 1 leaves the last stage exactly when its data returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_sr <= '0;
        end else begin
            tag_sr[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Drain sequencing: start, read issue, write-free reset slot search, finish.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            limit       <= '0;
            rd_ptr      <= '0;
            total       <= '0;
            timer       <= '0;
            drained_cnt <= '0;
            lost_cnt    <= '0;
        end else begin
            if (pop) begin
                total <= total + NUM_IDX_BIT'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        limit  <= buf_wr_idx;
                        rd_ptr <= '0;
                        total  <= '0;
                        timer  <= '0;
                        state  <= (buf_wr_idx == '0) ? S_CHECK : S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        rd_ptr <= rd_ptr + NUM_IDX_BIT'(1);
                    end
                    if (read_done) begin
                        timer <= '0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (grow) begin
                        limit <= buf_wr_idx;
                        state <= S_READ;
                    end else if (!buf_wr_en) begin
                        state <= S_FIN;
                    end else if (timeout_hit) begin
                        if (lost_cnt != 16'hFFFF) begin
                            lost_cnt <= lost_cnt + 16'd1;
                        end
                        state <= S_FIN;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: begin
                    drained_cnt <= total;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

    // Overflow flag latches until cleared; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (buf_wr_overflow) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

`ifdef H_PFN_DRAIN_STATS_EN
    // Wrapping activity counters for drains, streamed entries and stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_drains  <= '0;
            stat_entries <= '0;
            stat_stall   <= '0;
        end else begin
            if (done) begin
                stat_drains <= stat_drains + 32'd1;
            end
            if (pop) begin
                stat_entries <= stat_entries + 32'd1;
            end
            if (pfn_valid && !pfn_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule
